// File: rtl/port_wr_page_packer_pkg.sv
// Shared widths, FSM state encoding and packet descriptor type for the write-port page packer.
package wr_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LEN_W      = 9;
  localparam int unsigned PAGE_WORDS = 8;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned OFF_W      = $clog2(PAGE_WORDS);
  localparam int unsigned PAGE_W     = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAlloc = 2'd1,
    StWrite = 2'd2,
    StDesc  = 2'd3
  } packer_state_t;

  typedef struct packed {
    logic [PAGE_W-1:0] head;
    logic [PAGE_W-1:0] tail;
    logic [3:0]        dest;
    logic [2:0]        prior;
    logic [LEN_W-1:0]  len;
  } pkt_desc_t;

endpackage

// File: rtl/port_wr_page_packer_if.sv
// Packer bus: frontend stream, free-page allocator, SRAM and link writes, descriptor output.
// PACKER_STATS_EN adds the packet/word statistics outputs.
interface port_wr_page_packer_if;
  import wr_pkg::*;

  logic              start_pkt;
  logic [LEN_W-1:0]  pkt_len;
  logic [3:0]        pkt_dest;
  logic [2:0]        pkt_prior;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_data_vld;
  logic              pause;
  logic              pg_req;
  logic              pg_gnt;
  logic [PAGE_W-1:0] pg_id;
  logic              sram_wr_en;
  logic [ADDR_W-1:0] sram_wr_addr;
  logic [DATA_W-1:0] sram_wr_data;
  logic              link_wr_en;
  logic [PAGE_W-1:0] link_wr_page;
  logic [PAGE_W-1:0] link_wr_next;
  logic              desc_vld;
  logic              desc_rdy;
  logic [PAGE_W-1:0] desc_head;
  logic [PAGE_W-1:0] desc_tail;
  logic [3:0]        desc_dest;
  logic [2:0]        desc_prior;
  logic [LEN_W-1:0]  desc_len;
  logic              busy;
  logic              err;
`ifdef PACKER_STATS_EN
  logic [31:0]       stat_pkt_cnt;
  logic [31:0]       stat_word_cnt;
`endif

  // Environment side: frontend, allocator and queue manager.
  modport master (
    output start_pkt, pkt_len, pkt_dest, pkt_prior, xfer_data, xfer_data_vld,
    output pg_gnt, pg_id, desc_rdy,
    input  pause, pg_req, sram_wr_en, sram_wr_addr, sram_wr_data,
    input  link_wr_en, link_wr_page, link_wr_next,
    input  desc_vld, desc_head, desc_tail, desc_dest, desc_prior, desc_len, busy, err
`ifdef PACKER_STATS_EN
    , input stat_pkt_cnt, stat_word_cnt
`endif
  );

  // Packer side.
  modport slave (
    input  start_pkt, pkt_len, pkt_dest, pkt_prior, xfer_data, xfer_data_vld,
    input  pg_gnt, pg_id, desc_rdy,
    output pause, pg_req, sram_wr_en, sram_wr_addr, sram_wr_data,
    output link_wr_en, link_wr_page, link_wr_next,
    output desc_vld, desc_head, desc_tail, desc_dest, desc_prior, desc_len, busy, err
`ifdef PACKER_STATS_EN
    , output stat_pkt_cnt, stat_word_cnt
`endif
  );

endinterface

// File: rtl/port_wr_page_packer_desc_reg.sv
// One-entry descriptor holding register: load sets vld, vld && rdy clears it.
// Descriptor fields stay stable while vld is high and are kept after acceptance.
module port_wr_desc_reg
  import wr_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  pkt_desc_t load_desc,
  input  logic      rdy,
  output logic      vld,
  output pkt_desc_t desc
);

  logic      vld_q, vld_d;
  pkt_desc_t desc_q, desc_d;

  // Handshake next-state: load has priority so a fresh descriptor is never lost.
  always_comb begin
    vld_d  = vld_q;
    desc_d = desc_q;
    if (vld_q && rdy) begin
      vld_d = 1'b0;
    end
    if (load) begin
      vld_d  = 1'b1;
      desc_d = load_desc;
    end
  end

  // Descriptor state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      desc_q <= '0;
    end else begin
      vld_q  <= vld_d;
      desc_q <= desc_d;
    end
  end

  assign vld  = vld_q;
  assign desc = desc_q;

endmodule

// File: rtl/port_wr_page_packer.sv
// Packs the matched write-port stream into allocator pages, writes the page-link chain and
// emits one descriptor per packet. Optional macro PACKER_STATS_EN adds packet/word counters.
module port_wr_page_packer
  import wr_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  port_wr_page_packer_if.slave bus
);

  packer_state_t     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [3:0]        dest_q, dest_d;
  logic [2:0]        prior_q, prior_d;
  logic              first_q, first_d;
  logic [PAGE_W-1:0] cur_page_q, cur_page_d;
  logic [PAGE_W-1:0] head_q, head_d;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic              sram_wr_en_q, sram_wr_en_d;
  logic [ADDR_W-1:0] sram_wr_addr_q, sram_wr_addr_d;
  logic [DATA_W-1:0] sram_wr_data_q, sram_wr_data_d;
  logic              link_wr_en_q, link_wr_en_d;
  logic [PAGE_W-1:0] link_wr_page_q, link_wr_page_d;
  logic [PAGE_W-1:0] link_wr_next_q, link_wr_next_d;
  logic              err_q, err_d;
  logic              desc_load;
  pkt_desc_t         desc_in, desc_out;

  assign desc_in = '{head: head_q, tail: cur_page_q, dest: dest_q, prior: prior_q, len: len_q};

  // FSM next-state, latched packet fields and registered write/link strobes.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_cnt_d     = word_cnt_q;
    dest_d         = dest_q;
    prior_d        = prior_q;
    first_d        = first_q;
    cur_page_d     = cur_page_q;
    head_d         = head_q;
    offset_d       = offset_q;
    sram_wr_en_d   = 1'b0;
    sram_wr_addr_d = sram_wr_addr_q;
    sram_wr_data_d = sram_wr_data_q;
    link_wr_en_d   = 1'b0;
    link_wr_page_d = link_wr_page_q;
    link_wr_next_d = link_wr_next_q;
    desc_load      = 1'b0;
    // Stray inputs are dropped; err lands one cycle after the offending input.
    err_d = (bus.start_pkt && (state_q != StIdle)) ||
            (bus.xfer_data_vld && (state_q != StWrite));

    unique case (state_q)
      StIdle: begin
        if (bus.start_pkt) begin
          if (bus.pkt_len != '0) begin
            len_d      = bus.pkt_len;
            dest_d     = bus.pkt_dest;
            prior_d    = bus.pkt_prior;
            word_cnt_d = '0;
            first_d    = 1'b1;
            state_d    = StAlloc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAlloc: begin
        if (bus.pg_gnt) begin
          cur_page_d = bus.pg_id;
          offset_d   = '0;
          state_d    = StWrite;
          if (first_q) begin
            head_d  = bus.pg_id;
            first_d = 1'b0;
          end else begin
            link_wr_en_d   = 1'b1;
            link_wr_page_d = cur_page_q;
            link_wr_next_d = bus.pg_id;
          end
        end
      end
      StWrite: begin
        if (bus.xfer_data_vld) begin
          sram_wr_en_d   = 1'b1;
          sram_wr_addr_d = {cur_page_q, offset_q};
          sram_wr_data_d = bus.xfer_data;
          offset_d       = offset_q + OFF_W'(1);
          word_cnt_d     = word_cnt_q + LEN_W'(1);
          // Last word beats page-full so no trailing page is ever requested.
          if ((word_cnt_q + LEN_W'(1)) == len_q) begin
            desc_load = 1'b1;
            state_d   = StDesc;
          end else if (offset_q == OFF_W'(PAGE_WORDS - 1)) begin
            state_d = StAlloc;
          end
        end
      end
      StDesc: begin
        if (bus.desc_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; a mid-packet reset abandons any granted pages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      len_q          <= '0;
      word_cnt_q     <= '0;
      dest_q         <= '0;
      prior_q        <= '0;
      first_q        <= 1'b0;
      cur_page_q     <= '0;
      head_q         <= '0;
      offset_q       <= '0;
      sram_wr_en_q   <= 1'b0;
      sram_wr_addr_q <= '0;
      sram_wr_data_q <= '0;
      link_wr_en_q   <= 1'b0;
      link_wr_page_q <= '0;
      link_wr_next_q <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_cnt_q     <= word_cnt_d;
      dest_q         <= dest_d;
      prior_q        <= prior_d;
      first_q        <= first_d;
      cur_page_q     <= cur_page_d;
      head_q         <= head_d;
      offset_q       <= offset_d;
      sram_wr_en_q   <= sram_wr_en_d;
      sram_wr_addr_q <= sram_wr_addr_d;
      sram_wr_data_q <= sram_wr_data_d;
      link_wr_en_q   <= link_wr_en_d;
      link_wr_page_q <= link_wr_page_d;
      link_wr_next_q <= link_wr_next_d;
      err_q          <= err_d;
    end
  end

  port_wr_desc_reg u_desc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (desc_load),
    .load_desc (desc_in),
    .rdy       (bus.desc_rdy),
    .vld       (bus.desc_vld),
    .desc      (desc_out)
  );

  // pause/pg_req/busy decode the state register only.
  assign bus.pause        = (state_q == StAlloc) || (state_q == StDesc);
  assign bus.pg_req       = (state_q == StAlloc);
  assign bus.busy         = (state_q != StIdle);
  assign bus.err          = err_q;
  assign bus.sram_wr_en   = sram_wr_en_q;
  assign bus.sram_wr_addr = sram_wr_addr_q;
  assign bus.sram_wr_data = sram_wr_data_q;
  assign bus.link_wr_en   = link_wr_en_q;
  assign bus.link_wr_page = link_wr_page_q;
  assign bus.link_wr_next = link_wr_next_q;
  assign bus.desc_head    = desc_out.head;
  assign bus.desc_tail    = desc_out.tail;
  assign bus.desc_dest    = desc_out.dest;
  assign bus.desc_prior   = desc_out.prior;
  assign bus.desc_len     = desc_out.len;

`ifdef PACKER_STATS_EN
  logic        word_acc;
  logic [31:0] stat_pkt_cnt_q;
  logic [31:0] stat_word_cnt_q;

  assign word_acc = (state_q == StWrite) && bus.xfer_data_vld;

  // Packet and word statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_cnt_q  <= '0;
      stat_word_cnt_q <= '0;
    end else begin
      if (bus.desc_vld && bus.desc_rdy) begin
        stat_pkt_cnt_q <= stat_pkt_cnt_q + 32'd1;
      end
      if (word_acc) begin
        stat_word_cnt_q <= stat_word_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stat_pkt_cnt  = stat_pkt_cnt_q;
  assign bus.stat_word_cnt = stat_word_cnt_q;
`endif

endmodule

// File: tb/tb_port_wr_page_packer.sv
// Bench for port_wr_page_packer: scenario table, hand-written corner sequences and random
// packets, all checked against a page/word arithmetic reference model.
module tb_port_wr_page_packer;
  import wr_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  port_wr_page_packer_if bif ();

  port_wr_page_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bif.pause, bif.pg_req, bif.sram_wr_en, bif.sram_wr_addr, bif.sram_wr_data,
                 bif.link_wr_en, bif.link_wr_page, bif.link_wr_next, bif.desc_vld,
                 bif.desc_head, bif.desc_tail, bif.desc_dest, bif.desc_prior, bif.desc_len,
                 bif.busy, bif.err});
  endfunction

  function automatic logic [31:0] desc_now();
    return {bif.desc_head, bif.desc_tail, bif.desc_dest, bif.desc_prior, bif.desc_len};
  endfunction

  // Monitor: records what the DUT emits, sampled on the falling edge.
  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [2*PAGE_W-1:0]      link_q[$];
  int   mon_cyc = 0;
  int   last_wr_cyc, desc_cyc, err_cnt, req_cyc, pause_bad, wr_in_req, desc_unstable;
  bit   desc_seen;
  logic [31:0] desc_cap;

  always @(negedge clk) begin
    mon_cyc++;
    if (bif.sram_wr_en) begin
      wr_q.push_back({bif.sram_wr_addr, bif.sram_wr_data});
      last_wr_cyc = mon_cyc;
    end
    if (bif.link_wr_en) link_q.push_back({bif.link_wr_page, bif.link_wr_next});
    if (bif.err) err_cnt++;
    if (bif.pg_req) req_cyc++;
    if (bif.pg_req && bif.sram_wr_en) wr_in_req++;
    if (bif.pause !== (bif.pg_req || bif.desc_vld)) pause_bad++;
    if (bif.desc_vld) begin
      if (!desc_seen) begin
        desc_seen = 1'b1;
        desc_cap  = desc_now();
        desc_cyc  = mon_cyc;
      end else if (desc_now() !== desc_cap) begin
        desc_unstable++;
      end
    end
  end

  task automatic clear_mon();
    wr_q.delete();
    link_q.delete();
    err_cnt = 0; req_cyc = 0; pause_bad = 0; wr_in_req = 0; desc_unstable = 0;
    desc_seen = 1'b0; desc_cap = '0; desc_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic idle_inputs();
    bif.start_pkt = 1'b0; bif.pkt_len = '0; bif.pkt_dest = '0; bif.pkt_prior = '0;
    bif.xfer_data = '0; bif.xfer_data_vld = 1'b0; bif.pg_gnt = 1'b0; bif.pg_id = '0;
    bif.desc_rdy = 1'b0;
  endtask

  // Pages handed out by the allocator, in order.
  logic [PAGE_W-1:0] pages [64];

  // Drives one packet and checks it against the model: word i lands at
  // {pages[i/PAGE_WORDS], i%PAGE_WORDS}, ceil(len/PAGE_WORDS) pages, a link per extra page.
  task automatic run_pkt(input int len, input int dest, input int prior, input int gdly,
                         input int rdly, input bit gaps, input bit poke);
    logic [DATA_W-1:0] words[$];
    logic [ADDR_W-1:0] ea;
    int k, sent, given, dcnt, rcnt, n, last_sent;
    bit done, poked;
    k = (len + PAGE_WORDS - 1) / PAGE_WORDS;
    for (int i = 0; i < len; i++) words.push_back(DATA_W'($urandom));
    @(posedge clk); #1;
    clear_mon();
    bif.start_pkt = 1'b1; bif.pkt_len = LEN_W'(len);
    bif.pkt_dest = 4'(dest); bif.pkt_prior = 3'(prior);
    sent = 0; given = 0; dcnt = 0; rcnt = 0; n = 0; last_sent = 0; done = 0; poked = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      bif.start_pkt = 1'b0; bif.pg_gnt = 1'b0; bif.xfer_data_vld = 1'b0; bif.desc_rdy = 1'b0;
      if (bif.pg_req) begin
        if (dcnt >= gdly) begin
          bif.pg_gnt = 1'b1; bif.pg_id = pages[given % 64]; given++; dcnt = 0;
        end else begin
          dcnt++;
        end
      end else if (!bif.pause && bif.busy && sent < len) begin
        if (!gaps || $urandom_range(3) != 0) begin
          bif.xfer_data_vld = 1'b1; bif.xfer_data = words[sent]; sent++;
          last_sent = mon_cyc;
        end
      end else if (bif.desc_vld) begin
        if (poke && !poked) begin
          bif.start_pkt = 1'b1; bif.pkt_len = LEN_W'(7); poked = 1'b1;
        end else if (rcnt >= rdly) begin
          bif.desc_rdy = 1'b1; done = 1'b1;
        end else begin
          rcnt++;
        end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    check("pkt_done", done, 1);
    check("wr_count", wr_q.size(), len);
    for (int i = 0; i < len && i < wr_q.size(); i++) begin
      ea = {pages[i / PAGE_WORDS], OFF_W'(i % PAGE_WORDS)};
      check("wr_addr_data", wr_q[i], {ea, words[i]});
    end
    check("link_count", link_q.size(), k - 1);
    for (int j = 1; j < k && j <= link_q.size(); j++) begin
      check("link_pair", link_q[j-1], {pages[j-1], pages[j]});
    end
    check("page_grants", given, k);
    check("pg_req_cycles", req_cyc, k * (gdly + 1));
    check("pause_decode", pause_bad, 0);
    check("wr_during_req", wr_in_req, k - 1);
    check("desc_seen", desc_seen, 1);
    check("desc_fields", desc_cap,
          {pages[0], pages[k-1], 4'(dest), 3'(prior), LEN_W'(len)});
    check("desc_stable", desc_unstable, 0);
    check("last_wr_latency", last_wr_cyc, last_sent + 2);
    check("desc_latency", desc_cyc, last_sent + 2);
    check("err_pulses", err_cnt, poke ? 1 : 0);
    check("idle_after", bif.busy, 0);
  endtask

  typedef struct {
    int len; int dest; int prior; int gdly; int rdly; int p0; int p1; int p2; int poke;
    int first_a; int last_a; int links; int head; int tail;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    logic [ADDR_W-1:0] fa, la;
    vecs[0] = '{5,  1,  2, 0,  0,  3, 0, 0, 0, 24, 28, 0, 3,  3};
    vecs[1] = '{17, 2,  5, 0,  0,  3, 7, 9, 0, 24, 72, 2, 3,  9};
    vecs[2] = '{8,  3,  1, 0,  0,  4, 0, 0, 0, 32, 39, 0, 4,  4};
    vecs[3] = '{5,  4,  3, 10, 0,  6, 0, 0, 0, 48, 52, 0, 6,  6};
    vecs[4] = '{3,  5,  7, 0,  5, 10, 0, 0, 1, 80, 82, 0, 10, 10};
    vecs[5] = '{9,  15, 0, 0,  0,  1, 2, 0, 0, 8,  16, 1, 1,  2};

    idle_inputs();
    clear_mon();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_outputs", all_outs(), 0);

    // Scenario table.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 64; j++) pages[j] = PAGE_W'($urandom);
      pages[0] = PAGE_W'(vecs[i].p0);
      pages[1] = PAGE_W'(vecs[i].p1);
      pages[2] = PAGE_W'(vecs[i].p2);
      run_pkt(vecs[i].len, vecs[i].dest, vecs[i].prior, vecs[i].gdly, vecs[i].rdly, 1'b0,
              vecs[i].poke != 0);
      fa = (wr_q.size() > 0) ? wr_q[0][ADDR_W+DATA_W-1:DATA_W] : '1;
      la = (wr_q.size() > 0) ? wr_q[wr_q.size()-1][ADDR_W+DATA_W-1:DATA_W] : '1;
      check("tbl_first_addr", fa, vecs[i].first_a);
      check("tbl_last_addr", la, vecs[i].last_a);
      check("tbl_links", link_q.size(), vecs[i].links);
      check("tbl_head", desc_cap[31:24], vecs[i].head);
      check("tbl_tail", desc_cap[23:16], vecs[i].tail);
    end

    // Zero-length start in IDLE: err pulse, no packet.
    @(posedge clk); #1;
    bif.start_pkt = 1'b1; bif.pkt_len = '0;
    @(posedge clk); #1;
    bif.start_pkt = 1'b0;
    check("len0_err", bif.err, 1);
    check("len0_idle", bif.busy, 0);
    @(posedge clk); #1;
    check("len0_err_one_cycle", bif.err, 0);

    // Data word while IDLE: dropped with an err pulse.
    bif.xfer_data_vld = 1'b1; bif.xfer_data = 16'hbeef;
    @(posedge clk); #1;
    bif.xfer_data_vld = 1'b0;
    check("stray_vld_err", bif.err, 1);
    check("stray_vld_no_write", bif.sram_wr_en, 0);

    // Reset asserted mid-WRITE, then a fresh packet.
    bif.start_pkt = 1'b1; bif.pkt_len = LEN_W'(20); bif.pkt_dest = 4'd1; bif.pkt_prior = 3'd1;
    @(posedge clk); #1;
    bif.start_pkt = 1'b0;
    check("rst_seq_pg_req", bif.pg_req, 1);
    bif.pg_gnt = 1'b1; bif.pg_id = PAGE_W'(5);
    @(posedge clk); #1;
    bif.pg_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.xfer_data_vld = 1'b1; bif.xfer_data = DATA_W'(i + 1);
      @(posedge clk); #1;
    end
    check("rst_seq_busy_wr", {bif.busy, bif.sram_wr_en}, 2'b11);
    check("rst_seq_addr", bif.sram_wr_addr, 42);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_mid_write_outputs", all_outs(), 0);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 64; j++) pages[j] = PAGE_W'($urandom);
    pages[0] = PAGE_W'(12);
    run_pkt(5, 6, 2, 0, 0, 1'b0, 1'b0);

    // Length boundaries: single word, two full pages, maximum length.
    for (int j = 0; j < 64; j++) pages[j] = PAGE_W'($urandom);
    run_pkt(1, 7, 4, 1, 1, 1'b1, 1'b0);
    run_pkt(16, 8, 5, 0, 2, 1'b1, 1'b0);
    run_pkt(511, 9, 6, 0, 0, 1'b0, 1'b0);

    // Randomized packets.
    for (int r = 0; r < 25; r++) begin
      for (int j = 0; j < 64; j++) pages[j] = PAGE_W'($urandom);
      run_pkt($urandom_range(1, 40), $urandom_range(0, 15), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_wr_page_packer.md
Name: port_wr_page_packer

Overview:
- Sits directly downstream of port_wr_frontend on each write port.
- Consumes the frontend's matched packet stream: match_suc, the cur_* header fields, xfer_data and xfer_data_vld.
- Packs the stream into fixed-size SRAM pages, obtained one at a time from the free-page allocator, and writes the page-link chain.
- Emits one packet descriptor per packet to the queue manager, and back-pressures the frontend through pause.

Parameters:
- DATA_W, 16: data word width.
- LEN_W, 9: packet length field width, in words.
- PAGE_WORDS, 8: words per page; must be a power of 2.
- ADDR_W, 11: SRAM word-address width.
- PAGE_W, ADDR_W - $clog2(PAGE_WORDS) = 8: page-ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_pkt  in  1  one-cycle pulse, driven by the frontend's match_suc
- pkt_len  in  LEN_W  data-word count (cur_length)
- pkt_dest  in  4  destination port (cur_dest_port)
- pkt_prior  in  3  priority (cur_prior)
- xfer_data  in  DATA_W  data word
- xfer_data_vld  in  1  word valid
- pause  out  1  packer cannot accept a word
- pg_req  out  1  free-page request
- pg_gnt  in  1  grant; pg_id is valid in the same cycle
- pg_id  in  PAGE_W  granted page
- sram_wr_en  out  1  SRAM write strobe
- sram_wr_addr  out  ADDR_W  write address
- sram_wr_data  out  DATA_W  write data
- link_wr_en  out  1  page-link write strobe
- link_wr_page  out  PAGE_W  previous page
- link_wr_next  out  PAGE_W  newly linked page
- desc_vld  out  1  descriptor valid
- desc_rdy  in  1  descriptor accepted
- desc_head  out  PAGE_W  first page of the packet
- desc_tail  out  PAGE_W  last page of the packet
- desc_dest  out  4  latched destination port
- desc_prior  out  3  latched priority
- desc_len  out  LEN_W  latched length
- busy  out  1  state != IDLE
- err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and latched fields 0.
- States: IDLE, ALLOC, WRITE, DESC.
- IDLE:
  - On start_pkt with pkt_len != 0: latch len, dest and prior; clear word_cnt; set first=1; go to ALLOC.
  - On start_pkt with pkt_len == 0: stay in IDLE and pulse err.
- ALLOC:
  - pg_req=1, held until pg_gnt.
  - On pg_gnt: cur_page<=pg_id; offset<=0; go to WRITE.
  - If first: head<=pg_id, first<=0.
  - Otherwise: next cycle link_wr_en=1 with link_wr_page=old cur_page and link_wr_next=pg_id.
- WRITE:
  - A word is accepted when xfer_data_vld=1.
  - On acceptance: next cycle sram_wr_en=1, sram_wr_addr={cur_page, offset}, sram_wr_data=the word.
  - Also on acceptance: offset++ and word_cnt++.
  - If word_cnt+1 == len: tail<=cur_page and go to DESC. This takes priority over the page-full check.
  - Else if offset == PAGE_WORDS-1: go to ALLOC.
- DESC:
  - desc_vld=1, with desc_* stable until acceptance.
  - On desc_rdy: go to IDLE.
  - desc_vld may be high in the same cycle as desc_rdy.
- pause:
  - pause=1 in ALLOC and DESC; pause=0 in IDLE and WRITE.
  - pause is decoded from the state register only; there is no combinational path from any input.
  - Upstream must not assert xfer_data_vld while pause=1.
- Protocol errors (each drops the offending input and pulses err for one cycle):
  - xfer_data_vld outside WRITE.
  - start_pkt outside IDLE.
- Address arithmetic:
  - offset is $clog2(PAGE_WORDS) bits wide and wraps naturally.
  - Address = page concatenated with offset, no adder.
- Latency:
  - Accepted word to sram_wr_en: 1 cycle.
  - Final word to desc_vld: 1 cycle.
- Page count per packet is ceil(len/PAGE_WORDS). No page is requested beyond the last word; a packet with len == k*PAGE_WORDS uses exactly k pages.
- Reset mid-packet: everything returns to reset values asynchronously. Pages already granted are abandoned, so the allocator shares this reset.

Optional Feature:
- Macro: PACKER_STATS_EN.
- When defined, adds two outputs:
  - stat_pkt_cnt [31:0]: increments on each desc_vld && desc_rdy.
  - stat_word_cnt [31:0]: increments per accepted word.
  - Both wrap modulo 2^32 and reset to 0.
- When not defined, neither port nor the counters exist.

Decomposition:
- Shared package wr_pkg holds:
  - Width constants: DATA_W, LEN_W, PAGE_WORDS, PAGE_W, ADDR_W.
  - State enum packer_state_t.
  - Struct pkt_desc_t with head, tail, dest, prior, len.
- Natural sub-module: port_wr_desc_reg, a one-entry descriptor holding register with the vld/rdy handshake. The packer FSM and write path stay in the top module.

Test Plan:
- len=5, pg_gnt immediate with pg_id=3 -> 5 SRAM writes at addr 24..28, no link write, descriptor head=3 tail=3 len=5.
- len=17, grants 3, 7, 9 -> link writes (3->7) and (7->9); addresses 24..31, 56..63, 72; descriptor head=3 tail=9; pause=1 during each ALLOC.
- len=8, pg_id=4 -> addresses 32..39, exactly one pg_req, no link write, tail=head=4.
- pg_gnt delayed 10 cycles -> pause=1 and pg_req=1 for those 10 cycles, with no SRAM writes; then normal write-out.
- desc_rdy held low 5 cycles -> desc_vld and desc_* stable; start_pkt during DESC -> err pulse, packet ignored; start_pkt with len=0 in IDLE -> err pulse.
- rst_n asserted mid-WRITE -> all outputs 0 immediately, state IDLE; after release, a fresh len=5 packet completes normally.
